// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer and its interface.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUNNING = 2'd3
  } seq_state_t;

  // The counter only ever needs to reach the larger of the two intervals.
  function automatic int cnt_width(input int stretch, input int step);
    return $clog2(((stretch > step) ? stretch : step) + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Soft-reset request plus the sequenced reset/status outputs of one clock domain.
interface reset_sequencer_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_CHANNELS = 4
);
  logic                    soft_reset_req;
  logic                    sync_reset_out;
  logic [NUM_CHANNELS-1:0] channel_reset_n_out;
  logic                    reset_done;
  seq_state_t              seq_state_out;

  modport master (
    input  soft_reset_req,
    output sync_reset_out, channel_reset_n_out, reset_done, seq_state_out
  );

  modport slave (
    output soft_reset_req,
    input  sync_reset_out, channel_reset_n_out, reset_done, seq_state_out
  );
endinterface

// File: rtl/reset_sync_chain.sv
// Asynchronous-assert / synchronous-deassert reset synchroniser.
module reset_sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock_domain,
  input  logic async_reset_in,
  output logic sync_reset_out,
  output logic sync_next_out
);
  logic [SYNC_STAGES-1:0] stage_q, stage_d;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_d[gi] = 1'b1;
      end else begin : g_rest
        assign stage_d[gi] = stage_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clock_domain or negedge async_reset_in) begin
    if (!async_reset_in) stage_q <= '0;
    else                 stage_q <= stage_d;
  end

  assign sync_reset_out = stage_q[SYNC_STAGES-1];
  // Value the last stage will take on the coming edge; lets the FSM leave HOLD on that same edge.
  assign sync_next_out  = stage_d[SYNC_STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// Root reset controller: synchronise, stretch, then release channels one by one.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_CHANNELS   = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int STEP_CYCLES    = 8,
  parameter int RELEASE_ORDER  = 0
) (
  input logic              clock_domain,
  input logic              async_reset_in,
  reset_sequencer_if.master bus
);
  localparam int CNT_W = cnt_width(STRETCH_CYCLES, STEP_CYCLES);
  localparam int IDX_W = $clog2(NUM_CHANNELS) + 1;

  generate
    if (SYNC_STAGES < 2)    begin : g_bad_sync   $error("SYNC_STAGES must be >= 2");    end
    if (NUM_CHANNELS < 1)   begin : g_bad_chan   $error("NUM_CHANNELS must be >= 1");   end
    if (STRETCH_CYCLES < 1) begin : g_bad_str    $error("STRETCH_CYCLES must be >= 1"); end
    if (STEP_CYCLES < 1)    begin : g_bad_step   $error("STEP_CYCLES must be >= 1");    end
    if (RELEASE_ORDER != 0 && RELEASE_ORDER != 1) begin : g_bad_order
      $error("RELEASE_ORDER must be 0 or 1");
    end
  endgenerate

  seq_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_CHANNELS-1:0] chan_q, chan_d, release_mask;
  logic                    done_q, done_d;
  logic                    soft_q, soft_d;
  logic                    sync_out, sync_next;

  reset_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock_domain   (clock_domain),
    .async_reset_in (async_reset_in),
    .sync_reset_out (sync_out),
    .sync_next_out  (sync_next)
  );

  // Position idx_q in the release order maps to one output bit.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_map
      localparam int POS = (RELEASE_ORDER == 1) ? (NUM_CHANNELS - 1 - gi) : gi;
      assign release_mask[gi] = (idx_q == IDX_W'(POS));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    chan_d  = chan_q;
    done_d  = done_q;
    soft_d  = bus.soft_reset_req;
    if (soft_q && state_q != HOLD) begin
      state_d = STRETCH;
      cnt_d   = '0;
      idx_d   = '0;
      chan_d  = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (sync_next) begin
            state_d = STRETCH;
            cnt_d   = '0;
          end
        end
        STRETCH, RELEASE: begin
          if ((state_q == STRETCH && cnt_q == CNT_W'(STRETCH_CYCLES - 1)) ||
              (state_q == RELEASE && cnt_q == CNT_W'(STEP_CYCLES - 1))) begin
            chan_d = chan_q | release_mask;
            idx_d  = idx_q + IDX_W'(1);
            cnt_d  = '0;
            if (idx_q == IDX_W'(NUM_CHANNELS - 1)) begin
              state_d = RUNNING;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUNNING: ;
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge clock_domain or negedge async_reset_in) begin
    if (!async_reset_in) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      chan_q  <= '0;
      done_q  <= 1'b0;
      soft_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
      done_q  <= done_d;
      soft_q  <= soft_d;
    end
  end

  assign bus.sync_reset_out      = sync_out;
  assign bus.channel_reset_n_out = chan_q;
  assign bus.reset_done          = done_q;
  assign bus.seq_state_out       = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: ascending, descending and minimal configurations share one clock and reset.
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_CHANNELS(4)) if_a ();
  reset_sequencer_if #(.NUM_CHANNELS(4)) if_b ();
  reset_sequencer_if #(.NUM_CHANNELS(1)) if_c ();

  reset_sequencer #(.SYNC_STAGES(2), .NUM_CHANNELS(4), .STRETCH_CYCLES(16),
                    .STEP_CYCLES(8), .RELEASE_ORDER(0)) dut_a (
    .clock_domain(clk), .async_reset_in(rst_n), .bus(if_a.master));
  reset_sequencer #(.SYNC_STAGES(2), .NUM_CHANNELS(4), .STRETCH_CYCLES(16),
                    .STEP_CYCLES(8), .RELEASE_ORDER(1)) dut_b (
    .clock_domain(clk), .async_reset_in(rst_n), .bus(if_b.master));
  reset_sequencer #(.SYNC_STAGES(3), .NUM_CHANNELS(1), .STRETCH_CYCLES(1),
                    .STEP_CYCLES(8), .RELEASE_ORDER(0)) dut_c (
    .clock_domain(clk), .async_reset_in(rst_n), .bus(if_c.master));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand-computed checkpoints relative to E1, the first edge after release.
  int          tbl_edge  [10] = '{1, 2, 17, 18, 25, 26, 33, 34, 41, 42};
  logic [3:0]  tbl_chan_a[10] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF};
  logic [3:0]  tbl_chan_b[10] = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'hC, 4'hC, 4'hE, 4'hE, 4'hF};
  logic        tbl_sync  [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        tbl_done  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0]  tbl_state [10] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};

  // Releases rst_n between edges and checks up to last_edge.
  task automatic run_seq(input string name, input int last_edge);
    int p;
    p = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= last_edge; e++) begin
      @(posedge clk);
      #1;
      if (p < 10 && tbl_edge[p] == e) begin
        check_eq($sformatf("%s_a_chan_E%0d", name, e), 32'(if_a.channel_reset_n_out), 32'(tbl_chan_a[p]));
        check_eq($sformatf("%s_b_chan_E%0d", name, e), 32'(if_b.channel_reset_n_out), 32'(tbl_chan_b[p]));
        check_eq($sformatf("%s_a_sync_E%0d", name, e), 32'(if_a.sync_reset_out), 32'(tbl_sync[p]));
        check_eq($sformatf("%s_a_done_E%0d", name, e), 32'(if_a.reset_done), 32'(tbl_done[p]));
        check_eq($sformatf("%s_b_done_E%0d", name, e), 32'(if_b.reset_done), 32'(tbl_done[p]));
        check_eq($sformatf("%s_a_state_E%0d", name, e), 32'(if_a.seq_state_out), 32'(tbl_state[p]));
        p++;
      end
      if (e == 2) check_eq($sformatf("%s_c_sync_E2", name), 32'(if_c.sync_reset_out), 32'd0);
      if (e == 3) begin
        check_eq($sformatf("%s_c_sync_E3", name), 32'(if_c.sync_reset_out), 32'd1);
        check_eq($sformatf("%s_c_state_E3", name), 32'(if_c.seq_state_out), 32'd1);
        check_eq($sformatf("%s_c_chan_E3", name), 32'(if_c.channel_reset_n_out), 32'd0);
      end
      if (e == 4) begin
        check_eq($sformatf("%s_c_chan_E4", name), 32'(if_c.channel_reset_n_out), 32'd1);
        check_eq($sformatf("%s_c_done_E4", name), 32'(if_c.reset_done), 32'd1);
        check_eq($sformatf("%s_c_state_E4", name), 32'(if_c.seq_state_out), 32'd3);
      end
    end
    $display("seq %s: ran to E%0d, checks=%0d", name, last_edge, n_checks);
  endtask

  task automatic check_cleared(input string name);
    check_eq({name, "_a_chan"}, 32'(if_a.channel_reset_n_out), 32'd0);
    check_eq({name, "_b_chan"}, 32'(if_b.channel_reset_n_out), 32'd0);
    check_eq({name, "_c_chan"}, 32'(if_c.channel_reset_n_out), 32'd0);
    check_eq({name, "_a_sync"}, 32'(if_a.sync_reset_out), 32'd0);
    check_eq({name, "_a_done"}, 32'(if_a.reset_done), 32'd0);
    check_eq({name, "_a_state"}, 32'(if_a.seq_state_out), 32'd0);
  endtask

  initial begin
    if_a.soft_reset_req = 1'b0;
    if_b.soft_reset_req = 1'b0;
    if_c.soft_reset_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("por");

    run_seq("boot", 42);

    // Soft reset on A only: 3 high samples at s1..s3, first low sample at s4.
    if_a.soft_reset_req = 1'b1;
    for (int s = 1; s <= 44; s++) begin
      @(posedge clk);
      #1;
      if (s == 1)  check_eq("soft_s1_chan", 32'(if_a.channel_reset_n_out), 32'hF);
      if (s == 2) begin
        check_eq("soft_s2_chan", 32'(if_a.channel_reset_n_out), 32'h0);
        check_eq("soft_s2_done", 32'(if_a.reset_done), 32'd0);
        check_eq("soft_s2_state", 32'(if_a.seq_state_out), 32'd1);
        check_eq("soft_s2_sync", 32'(if_a.sync_reset_out), 32'd1);
        check_eq("soft_s2_b_chan", 32'(if_b.channel_reset_n_out), 32'hF);
      end
      if (s == 3)  if_a.soft_reset_req = 1'b0;
      if (s == 19) begin
        check_eq("soft_s19_chan", 32'(if_a.channel_reset_n_out), 32'h0);
        check_eq("soft_s19_state", 32'(if_a.seq_state_out), 32'd1);
      end
      if (s == 20) begin
        check_eq("soft_s20_chan", 32'(if_a.channel_reset_n_out), 32'h1);
        check_eq("soft_s20_state", 32'(if_a.seq_state_out), 32'd2);
      end
      if (s == 43) check_eq("soft_s43_done", 32'(if_a.reset_done), 32'd0);
      if (s == 44) begin
        check_eq("soft_s44_chan", 32'(if_a.channel_reset_n_out), 32'hF);
        check_eq("soft_s44_done", 32'(if_a.reset_done), 32'd1);
      end
    end
    $display("soft reset phase: checks=%0d", n_checks);

    // Mid-RELEASE async assertion between E30 and E31, then a full rerun.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    run_seq("pre_abort", 30);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("abort");
    repeat (2) @(posedge clk);
    run_seq("rerun", 42);

    // Glitch with no edge inside the low pulse.
    #2;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
    check_cleared("glitch");
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("glitch_a_sync_E%0d", e), 32'(if_a.sync_reset_out), (e >= 2) ? 32'd1 : 32'd0);
      check_eq($sformatf("glitch_c_sync_E%0d", e), 32'(if_c.sync_reset_out), (e >= 3) ? 32'd1 : 32'd0);
    end
    $display("glitch phase: checks=%0d", n_checks);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
